// File: rtl/axi_id_remap_pkg.sv
// AXI channel and request/response structs for the ID remapper.
// Wide types carry slave-port IDs, narrow types carry master-port IDs.
package axi_id_remap_pkg;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned DataW  = 32;
  localparam int unsigned StrbW  = DataW / 8;
  localparam int unsigned SlvIdW = 4;
  localparam int unsigned MstIdW = 2;

  typedef struct packed {
    logic [SlvIdW-1:0] id;
    logic [AddrW-1:0]  addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } wide_ax_t;

  typedef struct packed {
    logic [MstIdW-1:0] id;
    logic [AddrW-1:0]  addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
  } narrow_ax_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [SlvIdW-1:0] id;
    logic [1:0]        resp;
  } wide_b_t;

  typedef struct packed {
    logic [MstIdW-1:0] id;
    logic [1:0]        resp;
  } narrow_b_t;

  typedef struct packed {
    logic [SlvIdW-1:0] id;
    logic [DataW-1:0]  data;
    logic [1:0]        resp;
    logic              last;
  } wide_r_t;

  typedef struct packed {
    logic [MstIdW-1:0] id;
    logic [DataW-1:0]  data;
    logic [1:0]        resp;
    logic              last;
  } narrow_r_t;

  typedef struct packed {
    wide_ax_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    wide_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } wide_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    wide_b_t b;
    logic    b_valid;
    wide_r_t r;
    logic    r_valid;
  } wide_resp_t;

  typedef struct packed {
    narrow_ax_t aw;
    logic       aw_valid;
    w_chan_t    w;
    logic       w_valid;
    logic       b_ready;
    narrow_ax_t ar;
    logic       ar_valid;
    logic       r_ready;
  } narrow_req_t;

  typedef struct packed {
    logic      aw_ready;
    logic      ar_ready;
    logic      w_ready;
    narrow_b_t b;
    logic      b_valid;
    narrow_r_t r;
    logic      r_valid;
  } narrow_resp_t;

endpackage

// File: rtl/axi_id_remap_table.sv
// One direction of the ID remapper: tracks in-flight slave IDs,
// hands out the lowest free index and counts outstanding txns.
module axi_id_remap_table
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned MaxUniqIds   = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned IdxW         = 2,
  parameter int unsigned CntW         = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [IdWidth-1:0] push_id_i,
  output logic               full_o,
  output logic               hit_o,
  output logic [IdxW-1:0]    push_idx_o,
  input  logic               pop_i,
  input  logic [IdxW-1:0]    pop_idx_i,
  output logic [IdWidth-1:0] pop_id_o
);

  logic [MaxUniqIds-1:0] valid_q, valid_d;
  logic [IdWidth-1:0]    id_q  [MaxUniqIds];
  logic [IdWidth-1:0]    id_d  [MaxUniqIds];
  logic [CntW-1:0]       cnt_q [MaxUniqIds];
  logic [CntW-1:0]       cnt_d [MaxUniqIds];

  logic            hit, free_found, pop_ok;
  logic [IdxW-1:0] hit_idx, free_idx;

  // Lookup on registered state: matching entry and lowest free slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(MaxUniqIds); i++) begin
      if (valid_q[i] && id_q[i] == push_id_i) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
    for (int i = int'(MaxUniqIds) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign hit_o      = hit;
  assign push_idx_o = hit ? hit_idx : free_idx;
  assign full_o     = hit ? (cnt_q[hit_idx] == CntW'(MaxTxnsPerId))
                          : !free_found;

  assign pop_id_o = id_q[pop_idx_i];
  assign pop_ok   = pop_i && valid_q[pop_idx_i]
                    && (cnt_q[pop_idx_i] != '0);

  // Entry update; a push and pop on one entry cancel out.
  always_comb begin
    logic push_here, pop_here;
    valid_d   = valid_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    push_here = 1'b0;
    pop_here  = 1'b0;
    for (int i = 0; i < int'(MaxUniqIds); i++) begin
      push_here = push_i && (push_idx_o == IdxW'(i));
      pop_here  = pop_ok && (pop_idx_i == IdxW'(i));
      if (push_here && !pop_here) begin
        valid_d[i] = 1'b1;
        id_d[i]    = push_id_i;
        cnt_d[i]   = cnt_q[i] + 1'b1;
      end else if (pop_here && !push_here) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
        if (cnt_q[i] == CntW'(1)) valid_d[i] = 1'b0;
      end
    end
  end

  // Table state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(MaxUniqIds); i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(MaxUniqIds); i++) begin
        id_q[i]  <= id_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifndef SYNTHESIS
  // Flag responses that name an idle entry.
  always_ff @(posedge clk_i) begin
    if (rst_ni && pop_i) begin
      assert (valid_q[pop_idx_i] && cnt_q[pop_idx_i] != '0)
        else $error("pop of idle entry %0d", pop_idx_i);
    end
  end
`endif

endmodule

// File: rtl/axi_id_remap.sv
// Maps wide slave-port AXI IDs onto a dense master-port ID space,
// one table per direction, zero latency, no buffering.
module axi_id_remap
  import axi_id_remap_pkg::*;
#(
  parameter int unsigned AxiSlvPortIdWidth    = 4,
  parameter int unsigned AxiSlvPortMaxUniqIds = 4,
  parameter int unsigned AxiMaxTxnsPerId      = 4,
  parameter int unsigned AxiMstPortIdWidth    = 2,
  parameter type         slv_req_t            = wide_req_t,
  parameter type         slv_resp_t           = wide_resp_t,
  parameter type         mst_req_t            = narrow_req_t,
  parameter type         mst_resp_t           = narrow_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);

  localparam int unsigned IdxW = (AxiSlvPortMaxUniqIds > 1)
                               ? $clog2(AxiSlvPortMaxUniqIds) : 1;
  localparam int unsigned CntW = $clog2(AxiMaxTxnsPerId + 1);

  if (AxiMstPortIdWidth < $clog2(AxiSlvPortMaxUniqIds)) begin : g_e_mw
    $error("master ID width too small for table depth");
  end
  if (AxiMstPortIdWidth < 1) begin : g_e_mw1
    $error("master ID width must be at least 1");
  end
  if (AxiSlvPortMaxUniqIds < 1 || AxiMaxTxnsPerId < 1) begin : g_e_d
    $error("table depth and txns per ID must be at least 1");
  end
  if (AxiSlvPortMaxUniqIds > 2**AxiSlvPortIdWidth) begin : g_e_u
    $error("more unique IDs than the slave ID space holds");
  end
  if ($bits(slv_req_i.aw.id) != AxiSlvPortIdWidth) begin : g_e_si
    $error("slave struct ID width mismatch");
  end
  if ($bits(mst_req_o.aw.id) != AxiMstPortIdWidth) begin : g_e_mi
    $error("master struct ID width mismatch");
  end

  logic                         wr_full, wr_hit, wr_push, wr_pop;
  logic [IdxW-1:0]              wr_idx;
  logic [AxiSlvPortIdWidth-1:0] wr_pop_id;
  logic                         rd_full, rd_hit, rd_push, rd_pop;
  logic [IdxW-1:0]              rd_idx;
  logic [AxiSlvPortIdWidth-1:0] rd_pop_id;
  logic                         unused_hit;

  assign unused_hit = wr_hit ^ rd_hit;

  assign wr_push = slv_req_i.aw_valid & ~wr_full
                   & mst_resp_i.aw_ready;
  assign rd_push = slv_req_i.ar_valid & ~rd_full
                   & mst_resp_i.ar_ready;
  assign wr_pop  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign rd_pop  = mst_resp_i.r_valid & slv_req_i.r_ready
                   & mst_resp_i.r.last;

  axi_id_remap_table #(
    .IdWidth      (AxiSlvPortIdWidth),
    .MaxUniqIds   (AxiSlvPortMaxUniqIds),
    .MaxTxnsPerId (AxiMaxTxnsPerId),
    .IdxW         (IdxW),
    .CntW         (CntW)
  ) u_wr_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (wr_push),
    .push_id_i  (slv_req_i.aw.id),
    .full_o     (wr_full),
    .hit_o      (wr_hit),
    .push_idx_o (wr_idx),
    .pop_i      (wr_pop),
    .pop_idx_i  (mst_resp_i.b.id[IdxW-1:0]),
    .pop_id_o   (wr_pop_id)
  );

  axi_id_remap_table #(
    .IdWidth      (AxiSlvPortIdWidth),
    .MaxUniqIds   (AxiSlvPortMaxUniqIds),
    .MaxTxnsPerId (AxiMaxTxnsPerId),
    .IdxW         (IdxW),
    .CntW         (CntW)
  ) u_rd_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (rd_push),
    .push_id_i  (slv_req_i.ar.id),
    .full_o     (rd_full),
    .hit_o      (rd_hit),
    .push_idx_o (rd_idx),
    .pop_i      (rd_pop),
    .pop_idx_i  (mst_resp_i.r.id[IdxW-1:0]),
    .pop_id_o   (rd_pop_id)
  );

  // Downstream request: remapped IDs, stall gating, rest passes.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = AxiMstPortIdWidth'(wr_idx);
    mst_req_o.aw.addr  = slv_req_i.aw.addr;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw.lock  = slv_req_i.aw.lock;
    mst_req_o.aw.cache = slv_req_i.aw.cache;
    mst_req_o.aw.prot  = slv_req_i.aw.prot;
    mst_req_o.aw.qos   = slv_req_i.aw.qos;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~wr_full;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar.id    = AxiMstPortIdWidth'(rd_idx);
    mst_req_o.ar.addr  = slv_req_i.ar.addr;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar.lock  = slv_req_i.ar.lock;
    mst_req_o.ar.cache = slv_req_i.ar.cache;
    mst_req_o.ar.prot  = slv_req_i.ar.prot;
    mst_req_o.ar.qos   = slv_req_i.ar.qos;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~rd_full;
    mst_req_o.r_ready  = slv_req_i.r_ready;
  end

  // Upstream response: restored IDs, stall gating, rest passes.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~wr_full;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~rd_full;
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b.id     = wr_pop_id;
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b_valid  = mst_resp_i.b_valid;
    slv_resp_o.r.id     = rd_pop_id;
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r.last   = mst_resp_i.r.last;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
  end

endmodule

// File: tb/tb_axi_id_remap.sv
// Bench for axi_id_remap: directed scenarios plus random traffic
// checked against a per-slave-ID outstanding-count model.
module tb_axi_id_remap;
  import axi_id_remap_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  wide_req_t    slv_req;
  wide_resp_t   slv_resp;
  narrow_req_t  mst_req;
  narrow_resp_t mst_resp;

  int n_assert = 0;
  int n_fail   = 0;

  // model: [dir][slave id] -> outstanding count and master id
  int cnt_m [2][16];
  int map_m [2][16];

  always #5 clk = ~clk;

  axi_id_remap #(
    .AxiSlvPortIdWidth    (4),
    .AxiSlvPortMaxUniqIds (4),
    .AxiMaxTxnsPerId      (4),
    .AxiMstPortIdWidth    (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 16; s++) begin
        cnt_m[d][s] = 0;
        map_m[d][s] = 0;
      end
  endfunction

  function automatic int owner(input int d, input int m);
    for (int s = 0; s < 16; s++)
      if (cnt_m[d][s] > 0 && map_m[d][s] == m) return s;
    return -1;
  endfunction

  function automatic void lookup(input int d, input int s,
                                 output bit stall, output int m);
    stall = 1'b1;
    m = 0;
    if (cnt_m[d][s] > 0) begin
      stall = (cnt_m[d][s] == 4);
      m = map_m[d][s];
    end else begin
      for (int k = 3; k >= 0; k--)
        if (owner(d, k) < 0) begin
          stall = 1'b0;
          m = k;
        end
    end
  endfunction

  task automatic idle();
    slv_req.aw_valid    = 1'b0;
    slv_req.ar_valid    = 1'b0;
    slv_req.w_valid     = 1'b0;
    slv_req.b_ready     = 1'b1;
    slv_req.r_ready     = 1'b1;
    mst_resp.b_valid    = 1'b0;
    mst_resp.r_valid    = 1'b0;
    mst_resp.aw_ready   = 1'b1;
    mst_resp.ar_ready   = 1'b1;
    mst_resp.w_ready    = 1'b1;
  endtask

  task automatic aw(input int id);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = SlvIdW'(id);
    slv_req.aw.addr  = $urandom();
  endtask

  task automatic ar(input int id);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = SlvIdW'(id);
    slv_req.ar.addr  = $urandom();
  endtask

  task automatic b(input int mid);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = MstIdW'(mid);
  endtask

  task automatic r(input int mid, input bit last);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = MstIdW'(mid);
    mst_resp.r.last  = last;
    mst_resp.r.data  = $urandom();
  endtask

  // Check one cycle against the model, clock it, update the model.
  task automatic cycle();
    bit aw_st, ar_st, aw_hs, ar_hs, b_hs, r_hs;
    int aw_m, ar_m, b_s, r_s, aw_s, ar_s;
    aw_st = 0; ar_st = 0; aw_hs = 0; ar_hs = 0;
    b_hs = 0; r_hs = 0; aw_m = 0; ar_m = 0; b_s = 0; r_s = 0;
    #1;
    aw_s = int'(slv_req.aw.id);
    ar_s = int'(slv_req.ar.id);
    if (slv_req.aw_valid) begin
      lookup(0, aw_s, aw_st, aw_m);
      if (aw_st) begin
        chk("aw_stall_valid", 32'(mst_req.aw_valid), 0);
        chk("aw_stall_ready", 32'(slv_resp.aw_ready), 0);
      end else begin
        chk("aw_valid", 32'(mst_req.aw_valid), 1);
        chk("aw_id", 32'(mst_req.aw.id), aw_m);
        chk("aw_ready", 32'(slv_resp.aw_ready),
            32'(mst_resp.aw_ready));
        chk("aw_addr", mst_req.aw.addr, slv_req.aw.addr);
        aw_hs = mst_resp.aw_ready;
      end
    end else begin
      chk("aw_idle", 32'(mst_req.aw_valid), 0);
    end
    if (slv_req.ar_valid) begin
      lookup(1, ar_s, ar_st, ar_m);
      if (ar_st) begin
        chk("ar_stall_valid", 32'(mst_req.ar_valid), 0);
        chk("ar_stall_ready", 32'(slv_resp.ar_ready), 0);
      end else begin
        chk("ar_valid", 32'(mst_req.ar_valid), 1);
        chk("ar_id", 32'(mst_req.ar.id), ar_m);
        chk("ar_ready", 32'(slv_resp.ar_ready),
            32'(mst_resp.ar_ready));
        ar_hs = mst_resp.ar_ready;
      end
    end else begin
      chk("ar_idle", 32'(mst_req.ar_valid), 0);
    end
    if (mst_resp.b_valid) begin
      b_s = owner(0, int'(mst_resp.b.id));
      chk("b_id", 32'(slv_resp.b.id), b_s);
      chk("b_valid", 32'(slv_resp.b_valid), 1);
      b_hs = slv_req.b_ready;
    end
    if (mst_resp.r_valid) begin
      r_s = owner(1, int'(mst_resp.r.id));
      chk("r_id", 32'(slv_resp.r.id), r_s);
      chk("r_data", slv_resp.r.data, mst_resp.r.data);
      r_hs = slv_req.r_ready && mst_resp.r.last;
    end
    chk("w_data", mst_req.w.data, slv_req.w.data);
    @(posedge clk);
    if (aw_hs) begin
      if (cnt_m[0][aw_s] == 0) map_m[0][aw_s] = aw_m;
      cnt_m[0][aw_s]++;
    end
    if (ar_hs) begin
      if (cnt_m[1][ar_s] == 0) map_m[1][ar_s] = ar_m;
      cnt_m[1][ar_s]++;
    end
    if (b_hs) cnt_m[0][b_s]--;
    if (r_hs) cnt_m[1][r_s]--;
    #1;
    idle();
  endtask

  initial begin
    int q[$];
    slv_req  = '0;
    mst_resp = '0;
    model_clear();
    idle();

    // in reset: table empty, outputs follow inputs
    aw(5);
    #3;
    chk("rst_aw_valid", 32'(mst_req.aw_valid), 1);
    chk("rst_aw_id", 32'(mst_req.aw.id), 0);
    chk("rst_aw_ready", 32'(slv_resp.aw_ready), 1);
    mst_resp.aw_ready = 1'b0;
    #1;
    chk("rst_aw_ready_lo", 32'(slv_resp.aw_ready), 0);
    idle();
    #8;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // AW 0xA, 0x3, 0xA -> 0,1,0; B id 0 restores 0xA twice
    aw(4'hA); cycle();
    aw(4'h3); cycle();
    aw(4'hA); cycle();
    b(0); cycle();
    b(0); cycle();
    aw(4'h5); cycle();
    b(1); cycle();
    b(0); cycle();

    // AR table full, 5th ID stalls until an R last frees id 2
    ar(1); cycle();
    ar(2); cycle();
    ar(3); cycle();
    ar(4); cycle();
    ar(5); cycle();
    ar(5); r(2, 1'b1); cycle();
    ar(5); cycle();

    // per-ID limit: 5th AW 0x7 stalls until one B
    repeat (4) begin aw(7); cycle(); end
    aw(7); cycle();
    aw(7); b(0); cycle();
    aw(7); cycle();
    repeat (4) begin b(0); cycle(); end

    // R burst of 4 on mst id 0; only the last beat frees it
    repeat (3) begin ar(9); r(0, 1'b0); cycle(); end
    ar(9); r(0, 1'b1); cycle();
    ar(9); cycle();

    // same-cycle pop to zero and push of the same ID
    aw(4'hC); cycle();
    aw(4'hC); b(0); cycle();
    aw(4'hD); cycle();
    b(0); cycle();
    aw(4'hE); cycle();

    // async reset mid-burst with 3 read entries busy
    r(3, 1'b1); cycle();
    r(1, 1'b0); cycle();
    rst_n = 1'b0;
    ar(5);
    aw(4'hD);
    #2;
    chk("mid_rst_ar_id", 32'(mst_req.ar.id), 0);
    chk("mid_rst_ar_valid", 32'(mst_req.ar_valid), 1);
    chk("mid_rst_aw_id", 32'(mst_req.aw.id), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    aw(2); cycle();
    ar(4'hB); cycle();

    // random traffic
    for (int it = 0; it < 400; it++) begin
      slv_req.aw_valid  = 1'($urandom_range(0, 1));
      slv_req.aw.id     = SlvIdW'($urandom_range(0, 7));
      slv_req.aw.addr   = $urandom();
      mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
      slv_req.ar_valid  = 1'($urandom_range(0, 1));
      slv_req.ar.id     = SlvIdW'($urandom_range(0, 7));
      mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
      slv_req.w.data    = $urandom();
      slv_req.w_valid   = 1'($urandom_range(0, 1));
      q.delete();
      for (int m = 0; m < 4; m++) if (owner(0, m) >= 0) q.push_back(m);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        b(q[$urandom_range(0, q.size() - 1)]);
        slv_req.b_ready = ($urandom_range(0, 3) != 0);
      end
      q.delete();
      for (int m = 0; m < 4; m++) if (owner(1, m) >= 0) q.push_back(m);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        r(q[$urandom_range(0, q.size() - 1)],
          ($urandom_range(0, 2) == 0));
        slv_req.r_ready = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
